truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner_pkg.sv | 19 +
 rtl/truth_table_scanner.sv | 85 ++++++++
 tb/tb_truth_table_scanner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared scanner definitions: state encoding, pattern count and counter-width helper.
// Imported by the scanner and by its bench so both agree on NUM_PATTERNS.
package truth_table_scanner_pkg;

  localparam int NUM_PATTERNS = 8;
  localparam int IDX_W        = $clog2(NUM_PATTERNS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Hold counter must reach HOLD_CYCLES-1 without overflow for any legal setting.
  function automatic int hold_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/truth_table_scanner.sv
// Drives all 8 patterns onto {I0,I1,I2} and captures O into truth_table; done 8*HOLD_CYCLES+1 cycles after start.
// No backpressure: start is level-sampled in IDLE only and ignored while busy or done.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    I0,
  output logic                    I1,
  output logic                    I2,
  input  logic                    O,
  output logic [NUM_PATTERNS-1:0] truth_table,
  output logic                    busy,
  output logic                    done
);

  localparam int HOLD_W = hold_width(HOLD_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold;
  logic [IDX_W-1:0]  idx;
  logic              sample;
  logic              last_pat;

  assign sample   = (state == ST_DRIVE) && (hold == HOLD_W'(HOLD_CYCLES - 1));
  assign last_pat = (idx == IDX_W'(NUM_PATTERNS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_DRIVE;
      ST_DRIVE: if (sample && last_pat) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // O is only looked at on the last cycle of each pattern hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      hold        <= '0;
      truth_table <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            idx         <= '0;
            hold        <= '0;
            truth_table <= '0;
          end
        end
        ST_DRIVE: begin
          if (sample) begin
            truth_table[idx] <= O;
            hold             <= '0;
            idx              <= last_pat ? '0 : idx + IDX_W'(1);
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state == ST_DRIVE);
    done         = (state == ST_DONE);
    {I0, I1, I2} = (state == ST_DRIVE) ? idx : 3'b000;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench: two scanners (HOLD_CYCLES 5 and 1) each driving a behavioural `main` stage;
// expected tables are pushed on start acceptance and popped by a monitor on done.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [NI];
  int         mode_s  [NI];
  logic [7:0] lut_s   [NI];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference `main` stages: 0 = I0&I1|I2, 1 = parity, 2 = constant 0, 3 = random lookup.
  function automatic logic ref_o(input int mode, input logic [7:0] lut, input logic [2:0] p);
    logic a, b, c;
    a = p[2]; b = p[1]; c = p[0];
    case (mode)
      0:       return (a & b) | c;
      1:       return a ^ b ^ c;
      2:       return 1'b0;
      default: return lut[p];
    endcase
  endfunction

  function automatic logic [7:0] ref_table(input int mode, input logic [7:0] lut);
    logic [7:0] t;
    for (int k = 0; k < NUM_PATTERNS; k++) t[k] = ref_o(mode, lut, 3'(k));
    return t;
  endfunction

  typedef struct {
    logic [7:0] tbl;
    int         s;
  } exp_t;

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int H = (g == 0) ? 5 : 1;

    logic       i0, i1, i2, o, busy, done;
    logic       glitch = 1'b0;
    logic [7:0] tbl;

    exp_t       q[$];
    int         e        = 0;
    int         s        = 0;
    int         next_acc = 0;
    bit         act      = 1'b0;
    logic [7:0] cur      = 8'h00;
    logic [7:0] last_tbl = 8'h00;

    assign o = ref_o(mode_s[g], lut_s[g], {i0, i1, i2}) ^ glitch;

    truth_table_scanner #(.HOLD_CYCLES(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_s[g]),
      .I0          (i0),
      .I1          (i1),
      .I2          (i2),
      .O           (o),
      .truth_table (tbl),
      .busy        (busy),
      .done        (done)
    );

    // Timeline model: a scan spans edges s..s+8H+1, next start accepted from s+8H+2.
    always @(posedge clk) begin
      e++;
      if (rst) begin
        if (act) void'(q.pop_back());
        act      = 1'b0;
        next_acc = 0;
        last_tbl = 8'h00;
      end else begin
        if (act && (e - s) == 8 * H) last_tbl = cur;
        if (act && (e - s) > 8 * H) act = 1'b0;
        if (!act && e >= next_acc && start_s[g]) begin
          act      = 1'b1;
          s        = e;
          next_acc = e + 8 * H + 2;
          cur      = ref_table(mode_s[g], lut_s[g]);
          q.push_back('{tbl: cur, s: e});
        end
      end
    end

    always @(negedge clk) begin : monitor
      int         r, n;
      logic       exp_busy, exp_done, samp;
      logic [2:0] exp_pat;
      exp_t       it;
      if (rst) begin
        chk($sformatf("rst_outputs_%0d", g), {busy, done, i0, i1, i2, tbl}, 0);
        glitch = 1'b0;
      end else begin
        r        = e - s;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_pat  = 3'b000;
        if (act && r < 8 * H) begin
          exp_busy = 1'b1;
          exp_pat  = 3'(r / H);
        end else if (act && r == 8 * H) begin
          exp_done = 1'b1;
        end
        chk($sformatf("busy_%0d", g), busy, exp_busy);
        chk($sformatf("pattern_%0d", g), {i0, i1, i2}, exp_pat);
        chk($sformatf("done_%0d", g), done, exp_done);
        if (act && r == 0) chk($sformatf("table_clear_%0d", g), tbl, 8'h00);
        if (!act) chk($sformatf("table_hold_%0d", g), tbl, last_tbl);
        if (done) begin
          if (q.size() == 0) begin
            chk($sformatf("done_unexpected_%0d", g), 1, 0);
          end else begin
            it = q.pop_front();
            chk($sformatf("table_%0d", g), tbl, it.tbl);
            chk($sformatf("latency_%0d", g), e - it.s + 1, 8 * H + 1);
          end
        end
        // Disturb O on every edge that must not sample it.
        n      = e + 1 - s;
        samp   = act && n >= H && n <= 8 * H && (n % H) == 0;
        glitch = (mode_s[g] == 3 && !samp) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  function automatic bit idle(input int g);
    if (g == 0) return !inst[0].act && inst[0].q.size() == 0;
    return !inst[1].act && inst[1].q.size() == 0;
  endfunction

  task automatic wait_idle(input int g);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!idle(g) && n < 400);
    chk($sformatf("idle_timeout_%0d", g), idle(g), 1);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk); start_s[g] = 1'b1;
    @(negedge clk); start_s[g] = 1'b0;
  endtask

  task automatic check_async_zero();
    chk("async_rst_0", {inst[0].busy, inst[0].done, inst[0].i0, inst[0].i1, inst[0].i2, inst[0].tbl}, 0);
    chk("async_rst_1", {inst[1].busy, inst[1].done, inst[1].i0, inst[1].i1, inst[1].i2, inst[1].tbl}, 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0;
      mode_s[g]  = 0;
      lut_s[g]   = 8'h00;
    end
    #1 check_async_zero();
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // and-or stage, HOLD 5: table EA after 41 cycles
    mode_s[0] = 0;
    pulse_start(0);
    wait_idle(0);

    // O tied low after an EA scan, with an ignored start pulse mid-scan
    mode_s[0] = 2;
    pulse_start(0);
    repeat (10) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    wait_idle(0);

    // parity stage, HOLD 1: table 96 after 9 cycles
    mode_s[1] = 1;
    pulse_start(1);
    wait_idle(1);

    // reset asserted 12 cycles into a HOLD 5 scan
    mode_s[0] = 0;
    @(negedge clk); start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_s[0] = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_async_zero();
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start(0);
    wait_idle(0);

    // start held high: back-to-back scans on the HOLD 1 instance
    mode_s[1] = 3;
    lut_s[1]  = 8'($urandom);
    @(negedge clk); start_s[1] = 1'b1;
    repeat (40) @(negedge clk);
    start_s[1] = 1'b0;
    wait_idle(1);

    // random lookup stages with O glitches and random start traffic
    for (int k = 0; k < 3; k++) begin
      mode_s[0] = 3;
      lut_s[0]  = 8'($urandom);
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        start_s[0] = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk); start_s[0] = 1'b0;
      wait_idle(0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
